// File: rtl/lock_pkg.sv
// Shared types and default timing for the lock sequencer.
package lock_pkg;

    localparam int unsigned DEF_PW_LEN         = 4;
    localparam int unsigned DEF_MAX_FAILS      = 3;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 250_000_000;
    localparam int unsigned DEF_UNLOCK_CYCLES  = 500_000_000;
    localparam int unsigned DEF_RESULT_TIMEOUT = 15;
    localparam int unsigned TIMER_W            = 29;

    typedef enum logic [2:0] {
        IDLE,
        PROG,
        ENTRY,
        CHECK,
        WAIT,
        OPEN,
        LOCKOUT
    } state_t;

    // Single-cycle command pulses towards the code checker.
    typedef struct packed {
        logic store_value;
        logic input_value;
        logic compare;
        logic input_reset;
    } cmd_t;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer plus rising-edge detector for one button level.
// Ports: clk, resetn (sync, active-low), btn (async level), rise_c (edge, comb).
// All flops reset to 1 so a button held through reset yields no edge.
module btn_edge (
    input  logic clk,
    input  logic resetn,
    input  logic btn,
    output logic rise_c
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_c = sync2_q & ~prev_q;

endmodule

// File: rtl/lock_sequencer.sv
// Lock control FSM: converts button levels into checker command pulses,
// counts characters, waits for the compare result, holds unlock and
// enforces lockout after repeated failures.
// Ports: clk, resetn (sync, active-low); store_btn/input_btn/submit_btn
// (async levels); correct_password/invalid_password (checker result);
// store_value/input_value/compare/input_reset (1-cycle pulses);
// char_idx, unlock, sleep, fail_count (status). All outputs registered.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int unsigned PW_LEN         = DEF_PW_LEN,
    parameter int unsigned MAX_FAILS      = DEF_MAX_FAILS,
    parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int unsigned UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int unsigned RESULT_TIMEOUT = DEF_RESULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       store_btn,
    input  logic       input_btn,
    input  logic       submit_btn,
    input  logic       correct_password,
    input  logic       invalid_password,
    output logic       store_value,
    output logic       input_value,
    output logic       compare,
    output logic       input_reset,
    output logic [1:0] char_idx,
    output logic       unlock,
    output logic       sleep,
    output logic [1:0] fail_count
);

    // Internal count must reach PW_LEN; the port shows it modulo 4.
    localparam int unsigned CNT_W = $clog2(PW_LEN + 1);

    logic sto_rise, inp_rise, sub_rise;
    logic sto_e, inp_e, sub_e;

    state_t             state_q, state_d;
    cmd_t               cmd_q, cmd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         fail_q, fail_d, fail_inc;
    logic               unlock_q, unlock_d;
    logic               sleep_q, sleep_d;
    logic               pw_set_q, pw_set_d;
    logic               from_open_q, from_open_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               do_fail;

    btn_edge u_store  (.clk(clk), .resetn(resetn), .btn(store_btn),  .rise_c(sto_rise));
    btn_edge u_input  (.clk(clk), .resetn(resetn), .btn(input_btn),  .rise_c(inp_rise));
    btn_edge u_submit (.clk(clk), .resetn(resetn), .btn(submit_btn), .rise_c(sub_rise));

    // Same-cycle edges: submit beats input beats store; losers are dropped.
    assign sub_e = sub_rise;
    assign inp_e = inp_rise & ~sub_rise;
    assign sto_e = sto_rise & ~inp_rise & ~sub_rise;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            cnt_q       <= '0;
            fail_q      <= '0;
            unlock_q    <= 1'b0;
            sleep_q     <= 1'b0;
            pw_set_q    <= 1'b0;
            from_open_q <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            fail_q      <= fail_d;
            unlock_q    <= unlock_d;
            sleep_q     <= sleep_d;
            pw_set_q    <= pw_set_d;
            from_open_q <= from_open_d;
            timer_q     <= timer_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cmd_d       = '0;
        cnt_d       = cnt_q;
        fail_d      = fail_q;
        pw_set_d    = pw_set_q;
        from_open_d = from_open_q;
        fail_inc    = fail_q + 2'd1;
        do_fail     = 1'b0;

        case (state_q)
            IDLE: begin
                if (inp_e) begin
                    cmd_d.input_value = 1'b1;
                    cnt_d             = CNT_W'(1);
                    state_d           = ENTRY;
                end else if (sto_e && !pw_set_q) begin
                    from_open_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = PROG;
                end
            end
            PROG: begin
                if (sub_e) begin
                    cmd_d.input_reset = 1'b1;
                    cnt_d             = '0;
                    state_d           = from_open_q ? OPEN : IDLE;
                end else if (inp_e) begin
                    cmd_d.store_value = 1'b1;
                    if (cnt_q == CNT_W'(PW_LEN - 1)) begin
                        cmd_d.input_reset = 1'b1;
                        cnt_d             = '0;
                        pw_set_d          = 1'b1;
                        state_d           = from_open_q ? OPEN : IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ENTRY: begin
                if (sub_e) begin
                    if (cnt_q == CNT_W'(PW_LEN)) begin
                        cmd_d.compare = 1'b1;
                        state_d       = CHECK;
                    end else begin
                        do_fail = 1'b1;
                    end
                end else if (inp_e && (cnt_q < CNT_W'(PW_LEN))) begin
                    cmd_d.input_value = 1'b1;
                    cnt_d             = cnt_q + CNT_W'(1);
                end
            end
            // compare is high during CHECK, so WAIT only sees later results.
            CHECK: state_d = WAIT;
            WAIT: begin
                if (invalid_password) begin
                    do_fail = 1'b1;
                end else if (correct_password) begin
                    fail_d            = '0;
                    cmd_d.input_reset = 1'b1;
                    cnt_d             = '0;
                    state_d           = OPEN;
                end else if (timer_q == TIMER_W'(RESULT_TIMEOUT - 1)) begin
                    do_fail = 1'b1;
                end
            end
            OPEN: begin
                if (sub_e || (timer_q == TIMER_W'(UNLOCK_CYCLES - 1))) begin
                    state_d = IDLE;
                end else if (sto_e) begin
                    from_open_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = PROG;
                end
            end
            LOCKOUT: begin
                if (timer_q == TIMER_W'(LOCKOUT_CYCLES - 1)) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shared failure path from short submit, mismatch and timeout.
        if (do_fail) begin
            fail_d            = fail_inc;
            cmd_d.input_reset = 1'b1;
            cnt_d             = '0;
            state_d           = (fail_inc == 2'(MAX_FAILS)) ? LOCKOUT : IDLE;
        end

        unlock_d = (state_d == OPEN);
        sleep_d  = (state_d == LOCKOUT);
        // Timer restarts on every state entry.
        timer_d  = (state_d != state_q) ? '0 : timer_q + TIMER_W'(1);
    end

    assign store_value = cmd_q.store_value;
    assign input_value = cmd_q.input_value;
    assign compare     = cmd_q.compare;
    assign input_reset = cmd_q.input_reset;
    assign char_idx    = 2'(cnt_q);
    assign unlock      = unlock_q;
    assign sleep       = sleep_q;
    assign fail_count  = fail_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Scoreboard bench for lock_sequencer: stimulus queues expected output
// events, a negedge monitor pops and compares each observed event.
module tb_lock_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       store_btn = 1'b0;
    logic       input_btn = 1'b0;
    logic       submit_btn = 1'b0;
    logic       correct_password = 1'b0;
    logic       invalid_password = 1'b0;
    logic       store_value, input_value, compare, input_reset;
    logic [1:0] char_idx;
    logic       unlock, sleep;
    logic [1:0] fail_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] p;      // {store_value, input_value, compare, input_reset}
        logic [1:0] idx;
        logic [1:0] fails;
        logic       u;
        logic       s;
        int         hold;   // cycles unlock/sleep was high, on its falling event
        string      tag;
    } ev_t;

    ev_t expq[$];

    lock_sequencer #(
        .PW_LEN(4), .MAX_FAILS(3), .LOCKOUT_CYCLES(30),
        .UNLOCK_CYCLES(20), .RESULT_TIMEOUT(15)
    ) dut (
        .clk(clk), .resetn(resetn),
        .store_btn(store_btn), .input_btn(input_btn), .submit_btn(submit_btn),
        .correct_password(correct_password), .invalid_password(invalid_password),
        .store_value(store_value), .input_value(input_value),
        .compare(compare), .input_reset(input_reset),
        .char_idx(char_idx), .unlock(unlock), .sleep(sleep),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    task automatic push_ev(input logic [3:0] p, input logic [1:0] idx,
                           input logic [1:0] fails, input logic u, input logic s,
                           input int hold, input string tag);
        ev_t e;
        e.p = p; e.idx = idx; e.fails = fails; e.u = u; e.s = s;
        e.hold = hold; e.tag = tag;
        expq.push_back(e);
    endtask

    task automatic press(input logic s, input logic i, input logic b);
        @(posedge clk); #1;
        store_btn = s; input_btn = i; submit_btn = b;
        repeat (2) @(posedge clk);
        #1;
        store_btn = 1'b0; input_btn = 1'b0; submit_btn = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    // n input presses from an empty entry; index shown modulo 4.
    task automatic enter_chars(input int n, input logic [1:0] fails, input logic store);
        for (int k = 1; k <= n; k++) begin
            push_ev(store ? 4'b1000 | ((k == 4) ? 4'b0001 : 4'b0000) : 4'b0100,
                    2'(k % 4), fails, 1'b0, 1'b0, 0, store ? "store_chr" : "input_chr");
            press(1'b0, 1'b1, 1'b0);
        end
    endtask

    // kind 0: correct, 1: invalid, 2: no result.
    task automatic submit_result(input int kind, input int post);
        bit seen = 0;
        @(posedge clk); #1;
        submit_btn = 1'b1;
        for (int n = 0; n < 12 && !seen; n++) begin
            @(negedge clk);
            if (compare === 1'b1) seen = 1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL compare_wait: no compare within 12 cycles, required one");
        end
        submit_btn = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (kind == 0) correct_password = 1'b1;
        if (kind == 1) invalid_password = 1'b1;
        @(posedge clk); #1;
        correct_password = 1'b0; invalid_password = 1'b0;
        repeat (post) @(posedge clk);
    endtask

    task automatic check_zero(input string tag);
        logic [9:0] v;
        v = {store_value, input_value, compare, input_reset, char_idx, unlock, sleep, fail_count};
        checks++;
        if (v !== 10'b0) begin
            errors++;
            $display("FAIL %s: outputs=%b required=%b", tag, v, 10'b0);
        end
    endtask

    // Reset with input_btn held before, during and after reset.
    task automatic reset_holding_input(input string tag);
        @(posedge clk); #1;
        input_btn = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        check_zero(tag);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        input_btn = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    // Monitor: any pulse or unlock/sleep change is an event.
    initial begin : monitor
        logic pu, ps;
        int   uc, sc;
        ev_t  g, e;
        pu = 1'b0; ps = 1'b0; uc = 0; sc = 0;
        forever begin
            @(negedge clk);
            if (resetn !== 1'b1) begin
                pu = unlock; ps = sleep; uc = 0; sc = 0;
            end else begin
                g.p = {store_value, input_value, compare, input_reset};
                g.idx = char_idx; g.fails = fail_count; g.u = unlock; g.s = sleep;
                g.hold = 0;
                if (pu && !unlock) g.hold = uc;
                if (ps && !sleep) g.hold = sc;
                if (g.p != 4'b0 || unlock != pu || sleep != ps) begin
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event: got p=%b idx=%0d fails=%0d u=%b s=%b hold=%0d, required no event",
                                 g.p, g.idx, g.fails, g.u, g.s, g.hold);
                    end else begin
                        e = expq.pop_front();
                        if (g.p !== e.p || g.idx !== e.idx || g.fails !== e.fails ||
                            g.u !== e.u || g.s !== e.s || g.hold != e.hold) begin
                            errors++;
                            $display("FAIL %s: got p=%b idx=%0d fails=%0d u=%b s=%b hold=%0d, required p=%b idx=%0d fails=%0d u=%b s=%b hold=%0d",
                                     e.tag, g.p, g.idx, g.fails, g.u, g.s, g.hold,
                                     e.p, e.idx, e.fails, e.u, e.s, e.hold);
                        end
                    end
                end
                uc = unlock ? uc + 1 : 0;
                sc = sleep ? sc + 1 : 0;
                pu = unlock; ps = sleep;
            end
        end
    end

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        resetn = 1'b1;
        repeat (3) @(posedge clk);

        // Program: store then four characters; last one also clears input.
        press(1'b1, 1'b0, 1'b0);
        enter_chars(4, 2'd0, 1'b1);
        // Store in IDLE is ignored once a password is set.
        press(1'b1, 1'b0, 1'b0);

        // Correct entry: unlock held exactly 20 cycles.
        enter_chars(4, 2'd0, 1'b0);
        push_ev(4'b0010, 2'd0, 2'd0, 1'b0, 1'b0, 0,  "cmp_ok");
        push_ev(4'b0001, 2'd0, 2'd0, 1'b1, 1'b0, 0,  "open");
        push_ev(4'b0000, 2'd0, 2'd0, 1'b0, 1'b0, 20, "unlock_expire");
        submit_result(0, 25);

        // Failure 1: mismatch.
        enter_chars(4, 2'd0, 1'b0);
        push_ev(4'b0010, 2'd0, 2'd0, 1'b0, 1'b0, 0, "cmp_f1");
        push_ev(4'b0001, 2'd0, 2'd1, 1'b0, 1'b0, 0, "fail1_invalid");
        submit_result(1, 4);

        // Failure 2: result timeout.
        enter_chars(4, 2'd1, 1'b0);
        push_ev(4'b0010, 2'd0, 2'd1, 1'b0, 1'b0, 0, "cmp_f2");
        push_ev(4'b0001, 2'd0, 2'd2, 1'b0, 1'b0, 0, "fail2_timeout");
        submit_result(2, 20);

        // Failure 3: short entry, lockout for 30 cycles, buttons ignored.
        enter_chars(2, 2'd2, 1'b0);
        push_ev(4'b0001, 2'd0, 2'd3, 1'b0, 1'b1, 0,  "fail3_lockout");
        push_ev(4'b0000, 2'd0, 2'd0, 1'b0, 1'b0, 30, "lockout_end");
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        repeat (30) @(posedge clk);

        // Short entry: no compare, one failure.
        enter_chars(2, 2'd0, 1'b0);
        push_ev(4'b0001, 2'd0, 2'd1, 1'b0, 1'b0, 0, "short_entry");
        press(1'b0, 1'b0, 1'b1);

        // Input and submit together: only the submit (a short failure) acts.
        enter_chars(3, 2'd1, 1'b0);
        push_ev(4'b0001, 2'd0, 2'd2, 1'b0, 1'b0, 0, "sub_over_inp");
        press(1'b0, 1'b1, 1'b1);

        // Correct entry clears the failure count; reset while open.
        enter_chars(4, 2'd2, 1'b0);
        push_ev(4'b0010, 2'd0, 2'd2, 1'b0, 1'b0, 0, "cmp_ok2");
        push_ev(4'b0001, 2'd0, 2'd0, 1'b1, 1'b0, 0, "open2");
        submit_result(0, 3);
        reset_holding_input("rst_open");
        push_ev(4'b0100, 2'd1, 2'd0, 1'b0, 1'b0, 0, "post_rst_open");
        press(1'b0, 1'b1, 1'b0);

        // Three quick failures, then reset during lockout.
        push_ev(4'b0001, 2'd0, 2'd1, 1'b0, 1'b0, 0, "qf1");
        press(1'b0, 1'b0, 1'b1);
        enter_chars(1, 2'd1, 1'b0);
        push_ev(4'b0001, 2'd0, 2'd2, 1'b0, 1'b0, 0, "qf2");
        press(1'b0, 1'b0, 1'b1);
        enter_chars(1, 2'd2, 1'b0);
        push_ev(4'b0001, 2'd0, 2'd3, 1'b0, 1'b1, 0, "qf3_lockout");
        press(1'b0, 1'b0, 1'b1);
        reset_holding_input("rst_lockout");
        push_ev(4'b0100, 2'd1, 2'd0, 1'b0, 1'b0, 0, "post_rst_lockout");
        press(1'b0, 1'b1, 1'b0);
        repeat (10) @(posedge clk);

        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d expected events never seen (first %s), required 0",
                     expq.size(), expq[0].tag);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
